// File: rtl/pipe_pkg.sv
// pipe_pkg: scoreboard entry type, zero-register number and select-width helper
package pipe_pkg;
    localparam int XZR = 31;
    localparam int RD_MAXW = 8;
    typedef struct packed {
        logic               valid;
        logic [RD_MAXW-1:0] rd;
        logic               regwrite;
        logic               is_load;
    } sb_entry_t;
    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v >>= 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/sb_match.sv
// sb_match: per-stage RAW match vector and youngest-match forward select for one source operand
module sb_match
    import pipe_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = XZR,
    parameter int SW       = 2,
    parameter bit FWD      = 1'b0
) (
    input  sb_entry_t [STAGES-1:0] ent,
    input  logic [REG_AW-1:0]      src,
    input  logic                   used,
    output logic [STAGES-1:0]      match,
    output logic [SW-1:0]          sel
);
    logic live;
    assign live = used && src != REG_AW'(ZERO_REG);
    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_m
            assign match[g] = live && ent[g].valid && ent[g].regwrite && ent[g].rd == RD_MAXW'(src);
        end
    endgenerate
    // Scan oldest to youngest so the lowest matching stage wins; writeback is excluded
    always_comb begin
        sel = '0;
        for (int i = STAGES - 2; i >= 0; i--)
            if (FWD && match[i]) sel = SW'(i + 1);
    end
endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: RAW stall, branch flush and forwarding control; PIPE_SCOREBOARD_FWD_EN enables forwarding
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = XZR,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           id_valid,
    input  logic [REG_AW-1:0]              id_rn,
    input  logic [REG_AW-1:0]              id_rm,
    input  logic                           id_rn_used,
    input  logic                           id_rm_used,
    input  logic [REG_AW-1:0]              id_rd,
    input  logic                           id_regwrite,
    input  logic                           id_is_load,
    input  logic                           br_taken,
    output logic                           stall,
    output logic                           issue,
    output logic                           flush,
    output logic [clog2(STAGES+1)-1:0]     fwd_rn_sel,
    output logic [clog2(STAGES+1)-1:0]     fwd_rm_sel,
    output logic [STAGES-1:0]              stage_valid,
    output logic [clog2(STAGES+1)-1:0]     inflight,
    output logic [CNT_W-1:0]               stall_cycles
);
    localparam int FW = clog2(STAGES + 1);
`ifdef PIPE_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // With forwarding only a load in EX can stall; otherwise anything short of writeback does
    localparam logic [STAGES-1:0] HZ_STAGES = FWD ? STAGES'(1) : {1'b0, {(STAGES-1){1'b1}}};
    sb_entry_t [STAGES-1:0] pipe, nxt;
    sb_entry_t              dec;
    logic [STAGES-1:0]      rn_match, rm_match, ld;
    logic                   hazard;
    sb_match #(.STAGES(STAGES), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .SW(FW), .FWD(FWD)) u_rn (
        .ent(pipe), .src(id_rn), .used(id_rn_used), .match(rn_match), .sel(fwd_rn_sel)
    );
    sb_match #(.STAGES(STAGES), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .SW(FW), .FWD(FWD)) u_rm (
        .ent(pipe), .src(id_rm), .used(id_rm_used), .match(rm_match), .sel(fwd_rm_sel)
    );
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            ld[i]          = FWD ? pipe[i].is_load : 1'b1;
            stage_valid[i] = pipe[i].valid;
        end
        inflight = FW'($countones(stage_valid));
        hazard   = |((rn_match | rm_match) & HZ_STAGES & ld);
        flush    = br_taken;
        stall    = hazard && id_valid && !br_taken;
        issue    = id_valid && !stall && !br_taken;
        dec      = '{valid: 1'b1, rd: RD_MAXW'(id_rd),
                     regwrite: id_regwrite && id_rd != REG_AW'(ZERO_REG), is_load: id_is_load};
        nxt[0]   = issue ? dec : '0;
        for (int i = 1; i < STAGES; i++) begin
            nxt[i]       = pipe[i-1];
            nxt[i].valid = pipe[i-1].valid && !(br_taken && i <= BR_STAGE);
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe         <= '0;
            stall_cycles <= '0;
        end else begin
            pipe <= nxt;
            if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed checks of stall, flush, forwarding, counter saturation and async reset
module tb_pipe_scoreboard;
    localparam int ST = 3;
    localparam int AW = 5;
    localparam int CW = 4;
`ifdef PIPE_SCOREBOARD_FWD_EN
    localparam int NST = 1;
`else
    localparam int NST = 2;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic id_valid, id_rn_used, id_rm_used, id_regwrite, id_is_load, br_taken;
    logic [AW-1:0] id_rn, id_rm, id_rd;
    logic stall, issue, flush;
    logic [1:0] fwd_rn_sel, fwd_rm_sel, inflight;
    logic [ST-1:0] stage_valid;
    logic [CW-1:0] stall_cycles;
    int tests = 0;
    int fails = 0;

    pipe_scoreboard #(.STAGES(ST), .REG_AW(AW), .ZERO_REG(31), .BR_STAGE(1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .br_taken(br_taken),
        .stall(stall), .issue(issue), .flush(flush), .fwd_rn_sel(fwd_rn_sel),
        .fwd_rm_sel(fwd_rm_sel), .stage_valid(stage_valid), .inflight(inflight),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                       input logic rnu, input logic rmu, input logic [AW-1:0] rd,
                       input logic rw, input logic ldr);
        id_valid = v; id_rn = rn; id_rm = rm; id_rn_used = rnu; id_rm_used = rmu;
        id_rd = rd; id_regwrite = rw; id_is_load = ldr;
        #1;
    endtask

    task automatic idle();
        dec(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        br_taken = 1'b0;
        dec(1, 0, 0, 0, 0, 1, 1, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_issue", issue, 1);
        chk("rst_valid", stage_valid, 3'b000);
        chk("rst_inflight", inflight, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_fwd", {fwd_rn_sel, fwd_rm_sel}, 0);
        tick();
        chk("rst_hold_valid", stage_valid, 3'b000);
        reset = 1'b1;
        tick();
        idle();
        chk("shift_001", stage_valid, 3'b001);
        chk("shift_inflight", inflight, 1);
        tick();
        chk("shift_010", stage_valid, 3'b010);
        tick();
        chk("shift_100", stage_valid, 3'b100);
        tick();
        chk("shift_000", stage_valid, 3'b000);

        dec(1, 0, 0, 0, 0, 2, 1, 0);
        chk("add_issue", issue, 1);
        tick();
        dec(1, 2, 0, 1, 0, 4, 1, 0);
`ifdef PIPE_SCOREBOARD_FWD_EN
        chk("raw_fwd_stall", stall, 0);
        chk("raw_fwd_issue", issue, 1);
        chk("raw_fwd_rn", fwd_rn_sel, 1);
        tick();
        dec(1, 2, 4, 1, 1, 11, 1, 0);
        chk("raw_fwd2_valid", stage_valid, 3'b011);
        chk("raw_fwd2_rn", fwd_rn_sel, 2);
        chk("raw_fwd2_rm", fwd_rm_sel, 1);
        chk("raw_fwd2_stall", stall, 0);
`else
        chk("raw_stall1", stall, 1);
        chk("raw_issue1", issue, 0);
        tick();
        chk("raw_valid2", stage_valid, 3'b010);
        chk("raw_stall2", stall, 1);
        tick();
        chk("raw_stall3", stall, 0);
        chk("raw_issue3", issue, 1);
        chk("raw_fwd3", fwd_rn_sel, 0);
        chk("raw_cnt", stall_cycles, 2);
        tick();
        chk("raw_sub_in", stage_valid, 3'b001);
`endif
        idle();
        repeat (3) tick();

        dec(1, 0, 0, 0, 0, 3, 1, 1);
        tick();
        dec(1, 0, 3, 0, 1, 5, 1, 0);
        chk("lu_stall1", stall, 1);
        tick();
`ifdef PIPE_SCOREBOARD_FWD_EN
        chk("lu_stall2", stall, 0);
        chk("lu_issue2", issue, 1);
        chk("lu_fwd_rm", fwd_rm_sel, 2);
        tick();
        dec(1, 5, 0, 1, 0, 6, 1, 0);
        chk("alu_valid", stage_valid, 3'b101);
        chk("alu_stall", stall, 0);
        chk("alu_fwd_rn", fwd_rn_sel, 1);
`else
        chk("lu_stall2", stall, 1);
        tick();
        chk("lu_stall3", stall, 0);
        chk("lu_fwd_rm", fwd_rm_sel, 0);
        tick();
        dec(1, 5, 0, 1, 0, 6, 1, 0);
        chk("alu_valid", stage_valid, 3'b001);
        chk("alu_stall", stall, 1);
`endif
        idle();
        repeat (3) tick();
        chk("lu_cnt", stall_cycles, (NST == 1) ? 1 : 4);

        dec(1, 0, 0, 0, 0, 31, 1, 0);
        tick();
        dec(1, 31, 31, 1, 1, 12, 1, 0);
        chk("xzr_valid", stage_valid, 3'b001);
        chk("xzr_stall", stall, 0);
        chk("xzr_issue", issue, 1);
        chk("xzr_fwd", {fwd_rn_sel, fwd_rm_sel}, 0);
        tick();
        idle();
        repeat (3) tick();

        dec(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        dec(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        dec(1, 7, 0, 1, 0, 10, 1, 0);
        chk("br_pre_stall", stall, 1);
        br_taken = 1'b1;
        #1;
        chk("br_flush", flush, 1);
        chk("br_stall", stall, 0);
        chk("br_issue", issue, 0);
        tick();
        br_taken = 1'b0;
        idle();
        chk("br_valid", stage_valid, 3'b100);
        chk("br_inflight", inflight, 1);
        chk("br_cnt", stall_cycles, (NST == 1) ? 1 : 4);
        repeat (3) tick();

        for (int r = 0; r < 20 / NST; r++) begin
            dec(1, 0, 0, 0, 0, 8, 1, 1);
            tick();
            dec(1, 8, 0, 1, 0, 9, 1, 0);
            repeat (NST) tick();
            tick();
        end
        idle();
        chk("sat_cnt", stall_cycles, 15);
        repeat (3) tick();

        dec(1, 0, 0, 0, 0, 8, 1, 1);
        tick();
        dec(1, 8, 0, 1, 0, 9, 1, 0);
        chk("mid_stall", stall, 1);
        reset = 1'b0;
        #1;
        chk("mid_cnt", stall_cycles, 0);
        chk("mid_valid", stage_valid, 3'b000);
        chk("mid_stall_off", stall, 0);
        chk("mid_issue", issue, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("rel_issue", issue, 1);
        tick();
        idle();
        chk("rel_valid", stage_valid, 3'b001);
        chk("rel_cnt", stall_cycles, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
